// File: rtl/stream_mux_arb_if.sv
// Stream mux bus: N producer channels with valid/ready/last, one registered consumer port.
interface stream_mux_arb_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_last;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [WIDTH-1:0]          out_data;
    logic                      out_last;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    // Multiplexer side.
    modport slave (
        input  in_data, in_valid, in_last, mode, out_ready,
        output in_ready, out_data, out_last, out_sel, out_valid
    );

    // Producer/consumer side.
    modport master (
        output in_data, in_valid, in_last, mode, out_ready,
        input  in_ready, out_data, out_last, out_sel, out_valid
    );
endinterface

// File: rtl/stream_mux_arb.sv
// N-channel registered stream multiplexer with fixed-priority / round-robin
// arbitration and a packet lock that keeps the grant until the last beat.
module stream_mux_arb #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input logic            clk,
    input logic            rst_n,
    stream_mux_arb_if.slave bus
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e               state_q;
    logic [SEL_W-1:0]     lock_ch_q;
    logic [SEL_W-1:0]     rr_ptr_q;

    logic [WIDTH-1:0]     out_data_q;
    logic                 out_last_q;
    logic [SEL_W-1:0]     out_sel_q;
    logic                 out_valid_q;

    logic [2*CHANNELS-1:0] rr_dbl_c;
    logic [SEL_W-1:0]     rr_off_c;
    logic                 rr_hit_c;
    logic [SEL_W-1:0]     grant_c;
    logic                 sel_valid_c;
    logic                 sel_last_c;
    logic [WIDTH-1:0]     sel_data_c;
    logic                 load_c;
    logic                 xfer_c;
    logic [CHANNELS-1:0]  in_ready_c;

    // Modulo-CHANNELS addition of two channel indices (both already < CHANNELS).
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input logic [SEL_W-1:0] off);
        int unsigned sum;
        sum = 32'(base) + 32'(off);
        if (sum >= CHANNELS) begin
            sum = sum - CHANNELS;
        end
        return SEL_W'(sum);
    endfunction

    // Grant selection: locked channel in HOLD, otherwise fixed priority or rotated search.
    always_comb begin
        grant_c  = '0;
        rr_off_c = '0;
        rr_hit_c = 1'b0;
        // Rotating the doubled valid vector puts rr_ptr at bit 0, so the
        // lowest set bit is the round-robin offset.
        rr_dbl_c = {bus.in_valid, bus.in_valid} >> rr_ptr_q;
        for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
            if (rr_dbl_c[k]) begin
                rr_off_c = SEL_W'(k);
                rr_hit_c = 1'b1;
            end
        end
        if (state_q == ST_HOLD) begin
            grant_c = lock_ch_q;
        end else if (bus.mode) begin
            grant_c = rr_hit_c ? wrap_add(rr_ptr_q, rr_off_c) : '0;
        end else begin
            for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
                if (bus.in_valid[k]) begin
                    grant_c = SEL_W'(k);
                end
            end
        end
    end

    // Pick the granted channel's valid, data and last.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_last_c  = 1'b0;
        sel_data_c  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (grant_c == SEL_W'(i)) begin
                sel_valid_c = bus.in_valid[i];
                sel_last_c  = bus.in_last[i];
                sel_data_c  = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register can take a word when empty or being drained this cycle.
    assign load_c = !out_valid_q || bus.out_ready;
    // When nothing is valid in ARB the grant defaults to ch0, whose valid is then 0.
    assign xfer_c = load_c && sel_valid_c;

    // One-hot ready to the granted channel, forced low during reset.
    always_comb begin
        in_ready_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (rst_n && xfer_c && (grant_c == SEL_W'(i))) begin
                in_ready_c[i] = 1'b1;
            end
        end
    end

    // Packet lock FSM: enter HOLD on a non-last beat, leave on the locked channel's last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARB;
            lock_ch_q <= '0;
        end else if (xfer_c) begin
            case (state_q)
                ST_ARB: begin
                    if (!sel_last_c) begin
                        state_q   <= ST_HOLD;
                        lock_ch_q <= grant_c;
                    end
                end
                ST_HOLD: begin
                    if (sel_last_c) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    // Round-robin pointer moves past the channel that just finished a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (xfer_c && sel_last_c) begin
            rr_ptr_q <= wrap_add(grant_c, SEL_W'(1));
        end
    end

    // Output register: load on transfer, clear valid on drain, hold under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (load_c) begin
            if (xfer_c) begin
                out_data_q  <= sel_data_c;
                out_last_q  <= sel_last_c;
                out_sel_q   <= grant_c;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: directed scenarios plus randomized traffic against
// a transaction-level reference model.
module tb_stream_mux_arb;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned SEL_W    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_mux_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

    stream_mux_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Producer-side stimulus state.
    logic [CHANNELS-1:0] v_valid;
    logic [CHANNELS-1:0] v_last;
    logic [WIDTH-1:0]    v_data [CHANNELS];
    logic [CHANNELS-1:0] last_ready;

    // Reference model: locked channel (-1 = none), rr pointer, expected output register.
    int               m_lock;
    int               m_rr;
    logic             m_ov;
    logic             m_last;
    logic [WIDTH-1:0] m_data;
    int               m_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic bit_of(input logic [31:0] v, input int c);
        logic [31:0] t;
        t = v >> c;
        return t[0];
    endfunction

    function automatic logic [WIDTH-1:0] chan_data(input int c);
        logic [CHANNELS*WIDTH-1:0] t;
        t = bus.in_data >> (c * WIDTH);
        return t[WIDTH-1:0];
    endfunction

    // Which channel the rules say should be served now (-1: none).
    function automatic int model_grant();
        logic [31:0] v;
        int c;
        v = 32'(bus.in_valid);
        if (m_lock >= 0) return bit_of(v, m_lock) ? m_lock : -1;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            c = bus.mode ? (m_rr + k) % int'(CHANNELS) : k;
            if (bit_of(v, c)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_lock = -1;
        m_rr   = 0;
        m_ov   = 1'b0;
        m_last = 1'b0;
        m_data = '0;
        m_sel  = 0;
    endtask

    task automatic apply();
        for (int i = 0; i < int'(CHANNELS); i++) bus.in_data[i*WIDTH +: WIDTH] = v_data[i];
        bus.in_valid = v_valid;
        bus.in_last  = v_last;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic tick();
        int g;
        logic ld;
        logic [CHANNELS-1:0] er;
        apply();
        @(negedge clk);
        g  = model_grant();
        ld = !m_ov || bus.out_ready;
        er = '0;
        if (rst_n && ld && g >= 0) er = CHANNELS'(1) << g;
        check("in_ready", 32'(bus.in_ready), 32'(er));
        last_ready = bus.in_ready;
        @(posedge clk);
        if (rst_n && ld) begin
            if (g >= 0) begin
                m_ov   = 1'b1;
                m_data = chan_data(g);
                m_last = bit_of(32'(bus.in_last), g);
                m_sel  = g;
                if (m_last) begin
                    m_rr   = (g + 1) % int'(CHANNELS);
                    m_lock = -1;
                end else begin
                    m_lock = g;
                end
            end else begin
                m_ov = 1'b0;
            end
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("out_data",  32'(bus.out_data),  32'(m_data));
        check("out_last",  32'(bus.out_last),  32'(m_last));
        check("out_sel",   32'(bus.out_sel),   32'(m_sel));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'(0));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic all_valid_last();
        v_valid = '1;
        v_last  = '1;
        for (int i = 0; i < int'(CHANNELS); i++) v_data[i] = WIDTH'(i);
    endtask

    logic [WIDTH-1:0] hold_data;
    logic [SEL_W-1:0] hold_sel;

    initial begin
        // Reset with every channel valid.
        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        last_ready    = '0;
        all_valid_last();
        apply();
        model_reset();
        #12;
        check("reset_in_ready",  32'(bus.in_ready),  32'(0));
        check("reset_out_valid", 32'(bus.out_valid), 32'(0));
        check("reset_out_data",  32'(bus.out_data),  32'(0));
        check("reset_out_sel",   32'(bus.out_sel),   32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed priority: ch0 wins every cycle.
        for (int k = 0; k < 5; k++) begin
            tick();
            check("fp_sel",  32'(bus.out_sel),  32'(0));
            check("fp_data", 32'(bus.out_data), 32'(0));
        end

        // Round-robin from rr_ptr=0: 0,1,2,3,0 at full rate.
        do_reset();
        bus.mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_sel",   32'(bus.out_sel),   32'(k % 4));
            check("rr_data",  32'(bus.out_data),  32'(k % 4));
            check("rr_valid", 32'(bus.out_valid), 32'(1));
        end

        // Packet lock: move rr_ptr to 2, then ch2 sends a 3-beat packet while ch0/ch1 wait.
        do_reset();
        bus.mode = 1'b1;
        v_valid = 4'b0010; v_last = '1; v_data[1] = 8'h11;
        tick();
        v_valid = 4'b0111; v_last = 4'b0011;
        v_data[0] = 8'h10; v_data[1] = 8'h11;
        for (int b = 0; b < 3; b++) begin
            v_data[2] = WIDTH'(8'hC0 + b);
            v_last[2] = (b == 2);
            tick();
            check("lock_sel",  32'(bus.out_sel),  32'(2));
            check("lock_data", 32'(bus.out_data), 32'(8'hC0 + b));
        end
        v_valid[2] = 1'b0;
        tick();
        check("lock_wrap_sel", 32'(bus.out_sel), 32'(0));

        // Back-pressure: output frozen and no input accepted, then same-cycle refill.
        bus.mode = 1'b0;
        all_valid_last();
        tick();
        hold_data     = bus.out_data;
        hold_sel      = bus.out_sel;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_data",     32'(bus.out_data), 32'(hold_data));
            check("bp_sel",      32'(bus.out_sel),  32'(hold_sel));
            check("bp_in_ready", 32'(last_ready),   32'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(last_ready),    32'(1));
        check("bp_release_valid", 32'(bus.out_valid), 32'(1));

        // Reset mid-packet: two beats of a four-beat packet on ch1, then reset.
        v_valid = 4'b0010; v_last = '0; v_data[1] = 8'h5A;
        tick();
        tick();
        do_reset();
        bus.mode = 1'b1;
        all_valid_last();
        tick();
        check("midrst_sel", 32'(bus.out_sel), 32'(0));

        // Randomized traffic with stalls, packets and mode changes.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (!(v_valid[i] && !last_ready[i])) begin
                    v_valid[i] = ($urandom_range(0, 99) < 60);
                    v_data[i]  = WIDTH'($urandom);
                    v_last[i]  = ($urandom_range(0, 99) < 35);
                end
            end
            bus.out_ready = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 5) bus.mode = ~bus.mode;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised, registered N-channel stream multiplexer; successor to the team's 8-bit 4:1 combinational mux.
- Each input channel has a valid/ready handshake. The block arbitrates among the channels and forwards the winner's word into one output register.
- Arbitration mode is selectable: fixed priority or round-robin. A packet lock holds the grant on one channel until the beat marked last.
- Sits between multiple producers and one consumer in the datapath.

Parameters:
- WIDTH, 8, data width per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), width of the channel index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_last  in  CHANNELS  per-channel last-beat-of-packet flag.
- in_ready  out  CHANNELS  per-channel ready; one-hot or zero.
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- out_data  out  WIDTH  registered output word.
- out_last  out  1  registered last flag.
- out_sel  out  SEL_W  index of the channel that sourced out_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Round-robin pointer rr_ptr=0; FSM in ARB.
  - in_ready=0 while rst_n=0.
- Load enable: load = !out_valid || out_ready. The output register accepts a new word only when load=1.
- Grant logic (combinational, evaluated every cycle):
  - In ARB, mode=0: grant the lowest index i with in_valid[i]=1.
  - In ARB, mode=1: grant the first valid index searching from rr_ptr upward, wrapping CHANNELS-1 -> 0.
  - In HOLD: grant is fixed to lock_ch regardless of the other valids or mode.
- Ready: in_ready[g] = load && in_valid[g] for granted channel g; all other bits 0. No valid on the granted channel -> in_ready all 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= channel g data; out_last <= in_last[g]; out_sel <= g; out_valid <= 1.
  - Latency is exactly 1 cycle from input handshake to out_valid.
- No transfer while load=1: out_valid <= 0 next edge if out_ready drained the word. out_data, out_last and out_sel hold their values.
- load=0 (out_valid && !out_ready): all output registers hold and no input is accepted. Back-pressure never drops or duplicates a word.
- Round-robin pointer:
  - On every transfer with in_last[g]=1, rr_ptr <= (g+1) mod CHANNELS. This applies in either mode.
  - Transfers with in_last=0 do not move rr_ptr.
- FSM:
  - ARB -> HOLD on a transfer with in_last[g]=0; lock_ch <= g.
  - HOLD -> ARB on a transfer from lock_ch with in_last=1.
  - HOLD with lock_ch not valid: stay in HOLD and stall. Other channels never get a grant mid-packet.
  - Single-beat packets (in_last=1 on the first beat) leave the FSM in ARB.
- A mode change takes effect at the next ARB arbitration. It never breaks an active HOLD, and rr_ptr is preserved across mode changes.
- Simultaneous drain and load in one cycle (out_valid && out_ready && new transfer): the output register is replaced and out_valid stays 1. This gives full throughput of one word per cycle.
- Reset asserted mid-packet: all state returns to reset values immediately. The partial packet is abandoned; upstream is responsible for it.
- Channel data must be stable while in_valid=1 and not ready. Dropping in_valid without a handshake is permitted; the block does not check this.

Test Plan:
- Reset: assert rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0000. Release -> first transfer from ch0 (mode=0); out_data=8'h00 one cycle later.
- Fixed priority: mode=0, a=8'h00, b=8'h01, c=8'h02, d=8'h03, all valid, all last=1, out_ready=1 -> out_sel 0,0,0,...; out_data stays 8'h00 each cycle.
- Round-robin: same stimulus with mode=1 -> out_sel 0,1,2,3,0 and out_data 00,01,02,03,00 on consecutive cycles at one word per cycle.
- Packet lock: mode=1, ch2 sends 3 beats (last on beat 3) while ch0/ch1 are valid -> out_sel=2 for 3 consecutive words. Then grant goes to ch3 if valid, else wraps to ch0; rr_ptr=3 after the last beat.
- Back-pressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data/out_sel stable and in_ready=0000. Raise out_ready -> a new word is accepted the same cycle and out_valid stays 1.
- Reset mid-packet: in HOLD on ch1 after 2 of 4 beats, pulse rst_n low -> FSM back to ARB, out_valid=0; the next grant follows the mode from rr_ptr=0.
